res_station: RTL and testbench

RES_STATION -- requirements
Module: res_station

---
 rtl/rs_pkg.sv | 100 ++++++++++
 rtl/res_station_if.sv | 52 +++++
 rtl/rs_entry.sv | 16 +
 rtl/res_station.sv | 118 +++++++++++
 tb/tb_res_station.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Reservation-station types shared with the dispatch stage: payload/operand layout,
// broadcast bundle, and the operand readiness / wakeup helpers.
package rs_pkg;

    localparam int RS_DEPTH  = 8;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 32;
    localparam int PAYLOAD_W = 148;
    localparam int SRC_W     = 80;
    localparam int RESNUM_W  = 2;

    // Payload bit offsets (LSB of each field)
    localparam int PL_BPC_LSB       = 116;
    localparam int PL_NPC_LSB       = 84;
    localparam int PL_PDC_BIT       = 83;
    localparam int PL_BR_TYPE_LSB   = 81;
    localparam int PL_PADDR_LSB     = 49;
    localparam int PL_FUCONTROL_LSB = 45;
    localparam int PL_IMM_LSB       = 13;
    localparam int PL_RD_EN_BIT     = 12;
    localparam int PL_RD_P_LSB      = 6;
    localparam int PL_LSNUM_LSB     = 1;
    localparam int PL_MEMWRITE_BIT  = 0;

    // Operand bit offsets (LSB of each field)
    localparam int SRC_RS_EN_BIT   = 79;
    localparam int SRC_RS_P_LSB    = 73;
    localparam int SRC_RS_DATA_LSB = 41;
    localparam int SRC_RS_V_BIT    = 40;
    localparam int SRC_RT_EN_BIT   = 39;
    localparam int SRC_RT_P_LSB    = 33;
    localparam int SRC_RT_DATA_LSB = 1;
    localparam int SRC_RT_V_BIT    = 0;

    typedef struct packed {
        logic [31:0] bpc;
        logic [31:0] npc;
        logic        pdc;
        logic [1:0]  br_type;
        logic [31:0] paddr;
        logic [3:0]  fucontrol;
        logic [31:0] imm;
        logic        rd_en;
        logic [5:0]  rd_p;
        logic [4:0]  lsnum;
        logic        memwrite;
    } payload_t;

    typedef struct packed {
        logic              rs_en;
        logic [TAG_W-1:0]  rs_p;
        logic [DATA_W-1:0] rs_data;
        logic              rs_v;
        logic              rt_en;
        logic [TAG_W-1:0]  rt_p;
        logic [DATA_W-1:0] rt_data;
        logic              rt_v;
    } src_t;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_t;

    typedef struct packed {
        payload_t payload;
        src_t     src;
    } entry_t;

    function automatic logic src_ready(input src_t s);
        return (!s.rs_en || s.rs_v) && (!s.rt_en || s.rt_v);
    endfunction

    // Capture broadcast results into any still-pending operand; cdb1 has priority.
    function automatic src_t wake_src(input src_t s, input cdb_t c1, input cdb_t c2);
        src_t r;
        r = s;
        if (s.rs_en && !s.rs_v) begin
            if (c1.valid && (c1.tag == s.rs_p)) begin
                r.rs_data = c1.data;
                r.rs_v    = 1'b1;
            end else if (c2.valid && (c2.tag == s.rs_p)) begin
                r.rs_data = c2.data;
                r.rs_v    = 1'b1;
            end
        end
        if (s.rt_en && !s.rt_v) begin
            if (c1.valid && (c1.tag == s.rt_p)) begin
                r.rt_data = c1.data;
                r.rt_v    = 1'b1;
            end else if (c2.valid && (c2.tag == s.rt_p)) begin
                r.rt_data = c2.data;
                r.rt_v    = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/res_station_if.sv
// Dispatch/CDB/issue bundle of one reservation station; master = surrounding pipeline,
// slave = the station.
interface res_station_if
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                wr1_en;
    logic [RESNUM_W-1:0] wr1_resnum;
    payload_t            wr1_payload;
    src_t                wr1_src;
    logic                wr2_en;
    logic [RESNUM_W-1:0] wr2_resnum;
    payload_t            wr2_payload;
    src_t                wr2_src;

    logic                cdb1_valid;
    logic [TAG_W-1:0]    cdb1_tag;
    logic [DATA_W-1:0]   cdb1_data;
    logic                cdb2_valid;
    logic [TAG_W-1:0]    cdb2_tag;
    logic [DATA_W-1:0]   cdb2_data;

    logic                stall;
    logic                issue_valid;
    logic                issue_ready;
    payload_t            issue_payload;
    logic [DATA_W-1:0]   issue_rs_data;
    logic [DATA_W-1:0]   issue_rt_data;
    logic [CW-1:0]       count;

    modport master (
        output wr1_en, wr1_resnum, wr1_payload, wr1_src,
        output wr2_en, wr2_resnum, wr2_payload, wr2_src,
        output cdb1_valid, cdb1_tag, cdb1_data,
        output cdb2_valid, cdb2_tag, cdb2_data,
        output issue_ready,
        input  stall, issue_valid, issue_payload, issue_rs_data, issue_rt_data, count
    );

    modport slave (
        input  wr1_en, wr1_resnum, wr1_payload, wr1_src,
        input  wr2_en, wr2_resnum, wr2_payload, wr2_src,
        input  cdb1_valid, cdb1_tag, cdb1_data,
        input  cdb2_valid, cdb2_tag, cdb2_data,
        input  issue_ready,
        output stall, issue_valid, issue_payload, issue_rs_data, issue_rt_data, count
    );

endinterface

// File: rtl/rs_entry.sv
// One station slot: broadcast wakeup of its pending operands and its ready flag.
module rs_entry
    import rs_pkg::*;
(
    input  logic occupied,
    input  src_t src,
    input  cdb_t cdb1,
    input  cdb_t cdb2,
    output src_t woken,
    output logic ready
);

    assign woken = wake_src(src, cdb1, cdb2);
    assign ready = occupied && src_ready(src);

endmodule

// File: rtl/res_station.sv
// Age-ordered collapsing reservation station: two dispatch writes, two-port CDB wakeup,
// oldest-ready issue with same-edge compaction, and flush on recover.
module res_station
    import rs_pkg::*;
#(
    parameter logic [RESNUM_W-1:0] RS_ID = 2'd0,
    parameter int                  DEPTH = RS_DEPTH
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         recover,
    res_station_if.slave bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    // Occupancy is implied by count: slots [0, count) are valid, so only count is reset.
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_nxt;
    entry_t           ent [DEPTH];
    entry_t           nxt [DEPTH];
    src_t             woken [DEPTH];
    logic [DEPTH-1:0] occ;
    logic [DEPTH-1:0] rdy;

    logic             any_rdy;
    logic [IW-1:0]    sel;
    logic             stall;
    logic             do_issue;
    logic             acc1;
    logic             acc2;
    cdb_t             cdb1;
    cdb_t             cdb2;
    entry_t           wr1_ent;
    entry_t           wr2_ent;

    assign cdb1 = '{valid: bus.cdb1_valid, tag: bus.cdb1_tag, data: bus.cdb1_data};
    assign cdb2 = '{valid: bus.cdb2_valid, tag: bus.cdb2_tag, data: bus.cdb2_data};

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign occ[i] = (CW'(i) < count_q);
        rs_entry u_entry (
            .occupied (occ[i]),
            .src      (ent[i].src),
            .cdb1     (cdb1),
            .cdb2     (cdb2),
            .woken    (woken[i]),
            .ready    (rdy[i])
        );
    end

    always_comb begin
        any_rdy = 1'b0;
        sel     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (rdy[IW'(i)]) begin
                any_rdy = 1'b1;
                sel     = IW'(i);
            end
        end
    end

    assign stall    = (count_q > CW'(DEPTH - 2));
    assign do_issue = any_rdy && bus.issue_ready;
    assign acc1     = bus.wr1_en && (bus.wr1_resnum == RS_ID) && !stall && !recover;
    assign acc2     = bus.wr2_en && (bus.wr2_resnum == RS_ID) && !stall && !recover;

    // Incoming writes see same-cycle broadcasts so they never miss a wakeup.
    assign wr1_ent = '{payload: bus.wr1_payload, src: wake_src(bus.wr1_src, cdb1, cdb2)};
    assign wr2_ent = '{payload: bus.wr2_payload, src: wake_src(bus.wr2_src, cdb1, cdb2)};

    // Slots at or above the issued one pull from their upper neighbour; writes land at the
    // post-collapse tail, port 1 first.
    always_comb begin
        int base;
        int j;
        base = int'(count_q) - (do_issue ? 1 : 0);
        j    = 0;
        for (int i = 0; i < DEPTH; i++) begin
            nxt[IW'(i)] = ent[IW'(i)];
            j = (do_issue && (i >= int'(sel))) ? i + 1 : i;
            if (i < base) begin
                if (j < DEPTH) begin
                    nxt[IW'(i)].payload = ent[IW'(j)].payload;
                    nxt[IW'(i)].src     = woken[IW'(j)];
                end
            end else if (acc1 && (i == base)) begin
                nxt[IW'(i)] = wr1_ent;
            end else if (acc2 && (i == base + (acc1 ? 1 : 0))) begin
                nxt[IW'(i)] = wr2_ent;
            end
        end
    end

    assign count_nxt = recover ? '0 : (count_q - CW'(do_issue) + CW'(acc1) + CW'(acc2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        ent <= nxt;
    end

    assign bus.stall         = stall;
    assign bus.count         = count_q;
    assign bus.issue_valid   = any_rdy;
    assign bus.issue_payload = any_rdy ? ent[sel].payload     : '0;
    assign bus.issue_rs_data = any_rdy ? ent[sel].src.rs_data : '0;
    assign bus.issue_rt_data = any_rdy ? ent[sel].src.rt_data : '0;

endmodule

// File: tb/tb_res_station.sv
// Directed bench for res_station: a cycle table for ordering/wakeup/issue plus hand-written
// sequences for stall, recover and asynchronous reset.
module tb_res_station;
    import rs_pkg::*;

    localparam int         DEPTH = 8;
    localparam logic [1:0] ID    = 2'd1;

    logic clk = 1'b0;
    logic rst;
    logic recover;

    always #5 clk = ~clk;

    res_station_if #(.DEPTH(DEPTH)) bus ();

    res_station #(.RS_ID(ID), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .recover (recover),
        .bus     (bus)
    );

    typedef struct {
        logic        w1;
        logic [1:0]  r1;
        logic [7:0]  i1;
        src_t        s1;
        logic        w2;
        logic [7:0]  i2;
        src_t        s2;
        logic        c1v;
        logic [5:0]  c1t;
        logic [31:0] c1d;
        logic        c2v;
        logic [5:0]  c2t;
        logic [31:0] c2d;
        logic        ir;
        int          ecnt;
        logic        est;
        logic        eiv;
        logic [7:0]  eid;
        logic [31:0] ers;
        logic [31:0] ert;
    } vec_t;

    vec_t tbl [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic payload_t mk_pay(input logic [7:0] id);
        payload_t p;
        p           = '0;
        p.bpc       = {24'h000010, id};
        p.npc       = {24'hABCDEF, id};
        p.pdc       = id[3];
        p.br_type   = id[2:1];
        p.paddr     = {id, 24'h000000};
        p.fucontrol = id[3:0];
        p.imm       = {4{id}};
        p.rd_en     = id[0];
        p.rd_p      = id[5:0];
        p.lsnum     = id[4:0];
        p.memwrite  = id[1];
        return p;
    endfunction

    function automatic src_t s_rdy(input logic [31:0] a, input logic [31:0] b);
        src_t s;
        s = '{rs_en: 1'b1, rs_p: 6'd1, rs_data: a, rs_v: 1'b1,
              rt_en: 1'b1, rt_p: 6'd2, rt_data: b, rt_v: 1'b1};
        return s;
    endfunction

    function automatic src_t s_wrs(input logic [5:0] tag);
        src_t s;
        s = '0;
        s.rs_en = 1'b1;
        s.rs_p  = tag;
        return s;
    endfunction

    function automatic src_t s_wrt(input logic [5:0] tag);
        src_t s;
        s = '0;
        s.rt_en = 1'b1;
        s.rt_p  = tag;
        return s;
    endfunction

    task automatic chk(input string name, input logic [147:0] act, input logic [147:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic w1, input logic [1:0] r1, input logic [7:0] i1, input src_t s1,
                          input logic w2, input logic [7:0] i2, input src_t s2,
                          input logic ir, input logic rec);
        bus.wr1_en      = w1;
        bus.wr1_resnum  = r1;
        bus.wr1_payload = mk_pay(i1);
        bus.wr1_src     = s1;
        bus.wr2_en      = w2;
        bus.wr2_resnum  = ID;
        bus.wr2_payload = mk_pay(i2);
        bus.wr2_src     = s2;
        bus.cdb1_valid  = 1'b0;
        bus.cdb1_tag    = '0;
        bus.cdb1_data   = '0;
        bus.cdb2_valid  = 1'b0;
        bus.cdb2_tag    = '0;
        bus.cdb2_data   = '0;
        bus.issue_ready = ir;
        recover         = rec;
    endtask

    task automatic chk_out(input string tag, input int ecnt, input logic est, input logic eiv,
                           input logic [7:0] eid, input logic [31:0] ers, input logic [31:0] ert);
        payload_t ep;
        ep = eiv ? mk_pay(eid) : '0;
        chk({tag, ".count"},   148'(bus.count),         148'(ecnt));
        chk({tag, ".stall"},   148'(bus.stall),         148'(est));
        chk({tag, ".ivalid"},  148'(bus.issue_valid),   148'(eiv));
        chk({tag, ".payload"}, 148'(bus.issue_payload), 148'(ep));
        chk({tag, ".rs_data"}, 148'(bus.issue_rs_data), 148'(ers));
        chk({tag, ".rt_data"}, 148'(bus.issue_rt_data), 148'(ert));
    endtask

    task automatic add(input logic w1, input logic [1:0] r1, input logic [7:0] i1, input src_t s1,
                       input logic w2, input logic [7:0] i2, input src_t s2,
                       input logic c1v, input logic [5:0] c1t, input logic [31:0] c1d,
                       input logic c2v, input logic [5:0] c2t, input logic [31:0] c2d,
                       input logic ir, input int ecnt, input logic est, input logic eiv,
                       input logic [7:0] eid, input logic [31:0] ers, input logic [31:0] ert);
        vec_t v;
        v.w1 = w1;   v.r1 = r1;   v.i1 = i1;   v.s1 = s1;
        v.w2 = w2;   v.i2 = i2;   v.s2 = s2;
        v.c1v = c1v; v.c1t = c1t; v.c1d = c1d;
        v.c2v = c2v; v.c2t = c2t; v.c2d = c2d;
        v.ir = ir;   v.ecnt = ecnt; v.est = est; v.eiv = eiv;
        v.eid = eid; v.ers = ers; v.ert = ert;
        tbl.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        src_t z;
        z = '0;

        // w1 r1 id s1 | w2 id s2 | cdb1 | cdb2 | ir | count stall ivalid id rs rt (after the edge)
        add(1, ID,   8'd1, s_rdy(32'h11, 32'h22), 0, 8'd0, z, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,  0, 1, 0, 1, 8'd1, 32'h11, 32'h22);
        add(0, ID,   8'd0, z,                     0, 8'd0, z, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,  1, 0, 0, 0, 8'd0, 32'h0,  32'h0);
        add(1, ID,   8'd2, s_wrs(6'd12),          0, 8'd0, z, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,  0, 1, 0, 0, 8'd0, 32'h0,  32'h0);
        add(0, ID,   8'd0, z,                     0, 8'd0, z, 1, 6'd12, 32'hDEAD_BEEF, 0, 6'd0,  32'h0,  0, 1, 0, 1, 8'd2, 32'hDEAD_BEEF, 32'h0);
        add(1, 2'd0, 8'd3, s_rdy(32'h33, 32'h34), 0, 8'd0, z, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,  1, 0, 0, 0, 8'd0, 32'h0,  32'h0);
        add(1, ID,   8'd4, s_wrt(6'd9),           0, 8'd0, z, 1, 6'd9,  32'h1,         1, 6'd9,  32'h2,  0, 1, 0, 1, 8'd4, 32'h0,  32'h1);
        add(0, ID,   8'd0, z,                     0, 8'd0, z, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,  1, 0, 0, 0, 8'd0, 32'h0,  32'h0);
        add(1, ID,   8'd5, s_wrs(6'd20), 1, 8'd6, s_rdy(32'h61, 32'h62), 0, 6'd0, 32'h0, 0, 6'd0,  32'h0,  0, 2, 0, 1, 8'd6, 32'h61, 32'h62);
        add(0, ID,   8'd0, z,            1, 8'd7, s_rdy(32'h71, 32'h72), 0, 6'd0, 32'h0, 0, 6'd0,  32'h0,  0, 3, 0, 1, 8'd6, 32'h61, 32'h62);
        add(1, ID,   8'd8, s_rdy(32'h81, 32'h82), 1, 8'd9, s_rdy(32'h91, 32'h92), 0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 1, 4, 0, 1, 8'd7, 32'h71, 32'h72);
        add(0, ID,   8'd0, z,                     0, 8'd0, z, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,  1, 3, 0, 1, 8'd8, 32'h81, 32'h82);
        add(0, ID,   8'd0, z,                     0, 8'd0, z, 0, 6'd0,  32'h0,         1, 6'd20, 32'h55, 1, 2, 0, 1, 8'd5, 32'h55, 32'h0);
        add(0, ID,   8'd0, z,                     0, 8'd0, z, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,  1, 1, 0, 1, 8'd9, 32'h91, 32'h92);
        add(0, ID,   8'd0, z,                     0, 8'd0, z, 0, 6'd0,  32'h0,         0, 6'd0,  32'h0,  1, 0, 0, 0, 8'd0, 32'h0,  32'h0);

        rst = 1'b0;
        set_in(0, ID, 8'd0, z, 0, 8'd0, z, 0, 0);
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 8'd0, 32'h0, 32'h0);
        rst = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            set_in(tbl[k].w1, tbl[k].r1, tbl[k].i1, tbl[k].s1, tbl[k].w2, tbl[k].i2, tbl[k].s2, tbl[k].ir, 1'b0);
            bus.cdb1_valid = tbl[k].c1v;
            bus.cdb1_tag   = tbl[k].c1t;
            bus.cdb1_data  = tbl[k].c1d;
            bus.cdb2_valid = tbl[k].c2v;
            bus.cdb2_tag   = tbl[k].c2t;
            bus.cdb2_data  = tbl[k].c2d;
            tick();
            chk_out($sformatf("vec%0d", k), tbl[k].ecnt, tbl[k].est, tbl[k].eiv, tbl[k].eid, tbl[k].ers, tbl[k].ert);
        end

        // Fill to the stall threshold; only the three oldest entries are ever ready.
        set_in(1, ID, 8'd20, s_rdy(32'h2001, 32'h2002), 1, 8'd21, s_rdy(32'h2101, 32'h2102), 0, 0);
        tick();
        set_in(1, ID, 8'd22, s_rdy(32'h2201, 32'h2202), 1, 8'd23, s_wrs(6'd30), 0, 0);
        tick();
        set_in(1, ID, 8'd24, s_wrs(6'd30), 1, 8'd25, s_wrs(6'd30), 0, 0);
        tick();
        chk_out("fill6", 6, 0, 1, 8'd20, 32'h2001, 32'h2002);
        set_in(1, ID, 8'd26, s_wrs(6'd30), 0, 8'd0, z, 0, 0);
        tick();
        chk_out("fill7", 7, 1, 1, 8'd20, 32'h2001, 32'h2002);
        set_in(1, ID, 8'd27, s_rdy(32'h1, 32'h2), 1, 8'd28, s_rdy(32'h3, 32'h4), 0, 0);
        tick();
        chk_out("stall_wr", 7, 1, 1, 8'd20, 32'h2001, 32'h2002);
        set_in(0, ID, 8'd0, z, 0, 8'd0, z, 1, 0);
        tick();
        chk_out("unstall", 6, 0, 1, 8'd21, 32'h2101, 32'h2102);
        tick();
        chk_out("count5", 5, 0, 1, 8'd22, 32'h2201, 32'h2202);

        // Flush overrides a same-cycle write and issue; issue_valid reflects pre-flush state.
        set_in(1, ID, 8'd29, s_rdy(32'h5, 32'h6), 0, 8'd0, z, 1, 1);
        #1;
        chk("preflush.ivalid", 148'(bus.issue_valid), 148'(1'b1));
        chk("preflush.payload", 148'(bus.issue_payload), 148'(mk_pay(8'd22)));
        tick();
        chk_out("flush", 0, 0, 0, 8'd0, 32'h0, 32'h0);

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        set_in(1, ID, 8'd30, s_rdy(32'h3001, 32'h3002), 1, 8'd31, s_rdy(32'h3101, 32'h3102), 0, 0);
        tick();
        chk_out("refill", 2, 0, 1, 8'd30, 32'h3001, 32'h3002);
        set_in(0, ID, 8'd0, z, 0, 8'd0, z, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 8'd0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_out("post_rst", 0, 0, 0, 8'd0, 32'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
